// File: rtl/vic_writeback_buffer.sv
// Victim writeback buffer: queues lines evicted by vic_cache, drains them to memory with
// BUS_STORE requests and forwards still-buffered lines to dcache miss lookups.
module vic_writeback_buffer #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned OFFSET_BITS = 3,
  parameter int unsigned SET_BITS    = 4,
  parameter int unsigned TAG_BITS    = 13,
  localparam int unsigned LINE_W     = 1 + TAG_BITS + 64,
  localparam int unsigned CNT_W      = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W      = $clog2(DEPTH)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                fired_valid,
  input  logic [LINE_W-1:0]   fired_victim,
  input  logic [SET_BITS-1:0] fired_set_index,
  input  logic                snoop_valid,
  input  logic [SET_BITS-1:0] snoop_set_index,
  input  logic [TAG_BITS-1:0] snoop_tag,
  input  logic                bus_grant,
  input  logic [3:0]          mem2proc_response,
  output logic [1:0]          proc2mem_command,
  output logic [63:0]         proc2mem_addr,
  output logic [63:0]         proc2mem_data,
  output logic                snoop_hit,
  output logic [LINE_W-1:0]   snoop_line,
  output logic                wb_full,
  output logic                wb_empty,
  output logic [CNT_W-1:0]    wb_count,
  output logic                overflow_err
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_REQ    = 1'b1;
  localparam logic [1:0] BUS_NONE  = 2'h0;
  localparam logic [1:0] BUS_STORE = 2'h2;

  // Line layout: {valid, tag, data[63:0]}
  logic [LINE_W-1:0]   line_q [DEPTH];
  logic [SET_BITS-1:0] set_q  [DEPTH];
  logic [PTR_W-1:0]    head_q, tail_q;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [0:0]          state_q, state_d;
  logic                overflow_q;

  logic push_req, push, pop, full, drop;
  logic [LINE_W-1:0] head_line;
  logic [PTR_W-1:0]  snoop_idx;

  assign head_line = line_q[head_q];
  assign full      = (count_q == CNT_W'(DEPTH));

  always_comb begin
    push_req = fired_valid && fired_victim[LINE_W-1];
    pop      = (state_q == ST_REQ) && bus_grant && (mem2proc_response != 4'd0);
    push     = push_req && (!full || pop);
    drop     = push_req && full && !pop;

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end

    // Decide on the post-edge occupancy so a fresh entry reaches the bus one cycle after it fires.
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (count_d != '0) state_d = ST_REQ;
      ST_REQ:  if (count_d == '0) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        line_q[i] <= '0;
        set_q[i]  <= '0;
      end
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      state_q    <= ST_IDLE;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        line_q[tail_q] <= fired_victim;
        set_q[tail_q]  <= fired_set_index;
        tail_q         <= tail_q + PTR_W'(1);
      end
      if (pop) begin
        head_q <= head_q + PTR_W'(1);
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    if (state_q == ST_REQ) begin
      if (bus_grant) proc2mem_command = BUS_STORE;
      proc2mem_addr[OFFSET_BITS +: SET_BITS]            = set_q[head_q];
      proc2mem_addr[OFFSET_BITS + SET_BITS +: TAG_BITS] = head_line[64 +: TAG_BITS];
      proc2mem_data                                     = head_line[63:0];
    end
  end

  // Walk oldest to youngest so the last match (youngest) wins.
  always_comb begin
    snoop_hit  = 1'b0;
    snoop_line = '0;
    snoop_idx  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      snoop_idx = head_q + PTR_W'(i);
      if (snoop_valid && (CNT_W'(i) < count_q) && (set_q[snoop_idx] == snoop_set_index) &&
          (line_q[snoop_idx][64 +: TAG_BITS] == snoop_tag)) begin
        snoop_hit  = 1'b1;
        snoop_line = line_q[snoop_idx];
      end
    end
  end

  assign wb_full      = full;
  assign wb_empty     = (count_q == '0);
  assign wb_count     = count_q;
  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_vic_writeback_buffer.sv
// Bench for vic_writeback_buffer: directed scenarios plus randomized traffic checked against
// a queue-based model of the buffer contents.
module tb_vic_writeback_buffer;

  localparam int LW = 78;

  logic          clock = 1'b0;
  logic          reset;
  logic          fired_valid;
  logic [LW-1:0] fired_victim;
  logic [3:0]    fired_set_index;
  logic          snoop_valid;
  logic [3:0]    snoop_set_index;
  logic [12:0]   snoop_tag;
  logic          bus_grant;
  logic [3:0]    mem2proc_response;
  logic [1:0]    proc2mem_command;
  logic [63:0]   proc2mem_addr;
  logic [63:0]   proc2mem_data;
  logic          snoop_hit;
  logic [LW-1:0] snoop_line;
  logic          wb_full, wb_empty, overflow_err;
  logic [2:0]    wb_count;

  vic_writeback_buffer dut (
    .clock(clock), .reset(reset),
    .fired_valid(fired_valid), .fired_victim(fired_victim), .fired_set_index(fired_set_index),
    .snoop_valid(snoop_valid), .snoop_set_index(snoop_set_index), .snoop_tag(snoop_tag),
    .bus_grant(bus_grant), .mem2proc_response(mem2proc_response),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data), .snoop_hit(snoop_hit), .snoop_line(snoop_line),
    .wb_full(wb_full), .wb_empty(wb_empty), .wb_count(wb_count), .overflow_err(overflow_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [12:0] tag;
    logic [3:0]  set;
    logic [63:0] data;
  } ent_t;

  ent_t q[$];
  bit   m_ovf;
  int   n_vec = 0;
  int   n_err = 0;

  // Apply inputs at the falling edge and let combinational outputs settle.
  task automatic drive(input bit fv, input bit vb, input logic [12:0] tg, input logic [3:0] st,
                       input logic [63:0] dt, input bit g, input logic [3:0] r);
    @(negedge clock);
    fired_valid       = fv;
    fired_victim      = {vb, tg, dt};
    fired_set_index   = st;
    bus_grant         = g;
    mem2proc_response = r;
    #1;
  endtask

  // Clock edge; the model pops the head on an accepted store, then appends or drops the fire.
  task automatic advance();
    bit   pop, fire;
    ent_t e;
    pop    = bus_grant && (mem2proc_response != 4'd0) && (q.size() > 0);
    fire   = fired_valid && fired_victim[LW-1];
    e.tag  = fired_victim[77:64];
    e.set  = fired_set_index;
    e.data = fired_victim[63:0];
    @(posedge clock);
    if (pop) void'(q.pop_front());
    if (fire) begin
      if (q.size() < 4) q.push_back(e);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    fired_valid = 0; fired_victim = '0; fired_set_index = '0;
    snoop_valid = 0; snoop_set_index = '0; snoop_tag = '0;
    bus_grant = 0; mem2proc_response = '0;
    repeat (2) @(posedge clock);
    q.delete();
    m_ovf = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    fired_valid = 0; fired_victim = '0; fired_set_index = '0;
    snoop_valid = 0; snoop_set_index = '0; snoop_tag = '0;
    bus_grant = 1; mem2proc_response = '0;
    repeat (2) @(posedge clock);
    #1;
    n_vec++; if (wb_empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b want 1", wb_empty); end
    n_vec++; if (wb_count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", wb_count); end
    n_vec++; if (proc2mem_command !== 2'd0) begin n_err++; $display("FAIL reset_cmd got %0d want 0", proc2mem_command); end
    n_vec++; if (overflow_err !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", overflow_err); end
    n_vec++; if (wb_full !== 1'b0) begin n_err++; $display("FAIL reset_full got %b want 0", wb_full); end
    q.delete(); m_ovf = 0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_single_drain();
    do_reset();
    drive(1, 1, 13'd10, 4'd15, 64'd5, 1, 4'd0);
    n_vec++; if (proc2mem_command !== 2'd0) begin n_err++; $display("FAIL drain_pre_cmd got %0d want 0", proc2mem_command); end
    advance();
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, '0, '0, '0, 1, (k == 2) ? 4'd3 : 4'd0);
      n_vec++; if (proc2mem_command !== 2'd2) begin n_err++; $display("FAIL drain_cmd%0d got %0d want 2", k, proc2mem_command); end
      n_vec++; if (proc2mem_addr !== 64'd1400) begin n_err++; $display("FAIL drain_addr%0d got %0h want 578", k, proc2mem_addr); end
      n_vec++; if (proc2mem_data !== 64'd5) begin n_err++; $display("FAIL drain_data%0d got %0h want 5", k, proc2mem_data); end
      advance();
    end
    drive(0, 0, '0, '0, '0, 1, 4'd0);
    n_vec++; if (wb_empty !== 1'b1) begin n_err++; $display("FAIL drain_empty got %b want 1", wb_empty); end
    n_vec++; if (proc2mem_command !== 2'd0) begin n_err++; $display("FAIL drain_idle_cmd got %0d want 0", proc2mem_command); end
  endtask

  task automatic test_grant_withheld();
    do_reset();
    drive(1, 1, 13'd1, 4'd1, 64'h11, 0, 4'd0); advance();
    drive(1, 1, 13'd2, 4'd2, 64'h22, 0, 4'd1); advance();
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, '0, '0, '0, 0, 4'd1);
      n_vec++; if (proc2mem_command !== 2'd0) begin n_err++; $display("FAIL nogrant_cmd%0d got %0d want 0", k, proc2mem_command); end
      n_vec++; if (wb_count !== 3'd2) begin n_err++; $display("FAIL nogrant_count%0d got %0d want 2", k, wb_count); end
      advance();
    end
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, '0, '0, '0, 1, 4'd1);
      n_vec++; if (proc2mem_command !== 2'd2) begin n_err++; $display("FAIL grant_cmd%0d got %0d want 2", k, proc2mem_command); end
      n_vec++; if (proc2mem_data !== ((k == 0) ? 64'h11 : 64'h22)) begin n_err++; $display("FAIL grant_data%0d got %0h", k, proc2mem_data); end
      n_vec++; if (wb_count !== 3'(2 - k)) begin n_err++; $display("FAIL grant_count%0d got %0d want %0d", k, wb_count, 2 - k); end
      advance();
    end
    drive(0, 0, '0, '0, '0, 1, 4'd1);
    n_vec++; if (wb_count !== 3'd0) begin n_err++; $display("FAIL grant_count_end got %0d want 0", wb_count); end
  endtask

  task automatic test_overflow();
    logic [63:0] want [4] = '{64'd101, 64'd102, 64'd103, 64'd106};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(1, 1, 13'(k), 4'd3, 64'(100 + k), 0, 4'd0); advance();
      if (k == 3) begin
        #1;
        n_vec++; if (wb_full !== 1'b1) begin n_err++; $display("FAIL ovf_full got %b want 1", wb_full); end
        n_vec++; if (overflow_err !== 1'b0) begin n_err++; $display("FAIL ovf_early got %b want 0", overflow_err); end
      end
    end
    #1;
    n_vec++; if (overflow_err !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b want 1", overflow_err); end
    n_vec++; if (wb_count !== 3'd4) begin n_err++; $display("FAIL ovf_count got %0d want 4", wb_count); end
    drive(1, 1, 13'd6, 4'd3, 64'd106, 1, 4'd1);
    n_vec++; if (proc2mem_data !== 64'd100) begin n_err++; $display("FAIL ovf_head got %0d want 100", proc2mem_data); end
    advance();
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, '0, '0, '0, 1, 4'd2);
      n_vec++; if (wb_count !== 3'(4 - k)) begin n_err++; $display("FAIL ovf_drain_count%0d got %0d want %0d", k, wb_count, 4 - k); end
      n_vec++; if (proc2mem_data !== want[k]) begin n_err++; $display("FAIL ovf_order%0d got %0d want %0d", k, proc2mem_data, want[k]); end
      advance();
    end
    #1;
    n_vec++; if (overflow_err !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b want 1", overflow_err); end
  endtask

  task automatic test_snoop();
    do_reset();
    drive(1, 1, 13'd4, 4'd13, 64'd2, 0, 4'd0); advance();
    drive(1, 1, 13'd8, 4'd12, 64'd3, 0, 4'd0); advance();
    drive(0, 0, '0, '0, '0, 0, 4'd0);
    snoop_valid = 1; snoop_set_index = 4'd13; snoop_tag = 13'd4; #1;
    n_vec++; if (snoop_hit !== 1'b1) begin n_err++; $display("FAIL snoop_hit got %b want 1", snoop_hit); end
    n_vec++; if (snoop_line !== {1'b1, 13'd4, 64'd2}) begin n_err++; $display("FAIL snoop_line got %h", snoop_line); end
    snoop_tag = 13'd6; #1;
    n_vec++; if (snoop_hit !== 1'b0) begin n_err++; $display("FAIL snoop_miss got %b want 0", snoop_hit); end
    n_vec++; if (snoop_line !== '0) begin n_err++; $display("FAIL snoop_miss_line got %h want 0", snoop_line); end
    drive(1, 1, 13'd4, 4'd13, 64'd9, 0, 4'd0);
    snoop_set_index = 4'd13; snoop_tag = 13'd4; #1;
    n_vec++; if (snoop_line[63:0] !== 64'd2) begin n_err++; $display("FAIL snoop_same_edge got %0d want 2", snoop_line[63:0]); end
    advance();
    drive(0, 0, '0, '0, '0, 0, 4'd0);
    n_vec++; if (snoop_line[63:0] !== 64'd9) begin n_err++; $display("FAIL snoop_youngest got %0d want 9", snoop_line[63:0]); end
    snoop_valid = 0; #1;
    n_vec++; if (snoop_hit !== 1'b0) begin n_err++; $display("FAIL snoop_invalid got %b want 0", snoop_hit); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1, 1, 13'd7, 4'd5, 64'd77, 1, 4'd0); advance();
    drive(0, 0, '0, '0, '0, 1, 4'd0);
    n_vec++; if (proc2mem_command !== 2'd2) begin n_err++; $display("FAIL mid_req_cmd got %0d want 2", proc2mem_command); end
    #1 reset = 1'b0;
    #1;
    n_vec++; if (proc2mem_command !== 2'd0) begin n_err++; $display("FAIL mid_reset_cmd got %0d want 0", proc2mem_command); end
    n_vec++; if (wb_count !== 3'd0) begin n_err++; $display("FAIL mid_reset_count got %0d want 0", wb_count); end
    q.delete(); m_ovf = 0;
    @(negedge clock);
    reset = 1'b1;
    drive(0, 0, '0, '0, '0, 1, 4'd1);
    n_vec++; if (wb_empty !== 1'b1) begin n_err++; $display("FAIL mid_after_empty got %b want 1", wb_empty); end
  endtask

  task automatic test_random();
    logic [1:0]    e_cmd;
    logic [63:0]   e_addr, e_data;
    logic          e_hit;
    logic [LW-1:0] e_line;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 3) != 0, 13'($urandom_range(0, 3)),
            4'($urandom_range(0, 3)), {$urandom, $urandom}, $urandom_range(0, 4) < 3,
            ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'd0);
      snoop_valid = $urandom_range(0, 3) != 0;
      snoop_set_index = 4'($urandom_range(0, 3));
      snoop_tag = 13'($urandom_range(0, 3));
      #1;
      e_cmd  = (bus_grant && q.size() > 0) ? 2'd2 : 2'd0;
      e_addr = (q.size() > 0) ? 64'({q[0].tag, q[0].set, 3'b000}) : 64'd0;
      e_data = (q.size() > 0) ? q[0].data : 64'd0;
      e_hit  = 1'b0;
      e_line = '0;
      if (snoop_valid) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
          if (q[i].tag == snoop_tag && q[i].set == snoop_set_index) begin
            e_hit = 1'b1; e_line = {1'b1, q[i].tag, q[i].data};
            break;
          end
        end
      end
      n_vec++; if (proc2mem_command !== e_cmd) begin n_err++; $display("FAIL rnd_cmd c=%0d got %0d want %0d", c, proc2mem_command, e_cmd); end
      n_vec++; if (proc2mem_addr !== e_addr) begin n_err++; $display("FAIL rnd_addr c=%0d got %h want %h", c, proc2mem_addr, e_addr); end
      n_vec++; if (proc2mem_data !== e_data) begin n_err++; $display("FAIL rnd_data c=%0d got %h want %h", c, proc2mem_data, e_data); end
      n_vec++; if (wb_count !== 3'(q.size())) begin n_err++; $display("FAIL rnd_count c=%0d got %0d want %0d", c, wb_count, q.size()); end
      n_vec++; if (wb_full !== (q.size() == 4)) begin n_err++; $display("FAIL rnd_full c=%0d got %b", c, wb_full); end
      n_vec++; if (wb_empty !== (q.size() == 0)) begin n_err++; $display("FAIL rnd_empty c=%0d got %b", c, wb_empty); end
      n_vec++; if (overflow_err !== m_ovf) begin n_err++; $display("FAIL rnd_ovf c=%0d got %b want %b", c, overflow_err, m_ovf); end
      n_vec++; if (snoop_hit !== e_hit) begin n_err++; $display("FAIL rnd_hit c=%0d got %b want %b", c, snoop_hit, e_hit); end
      n_vec++; if (snoop_line !== e_line) begin n_err++; $display("FAIL rnd_line c=%0d got %h want %h", c, snoop_line, e_line); end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_single_drain();
    test_grant_withheld();
    test_overflow();
    test_snoop();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
